// File: rtl/desc_bank_loader.sv
// Descriptor bank loader: assembles IN_W-bit beats MSB-first into DESC_BITS-bit
// descriptors and commits them into NUM_DESC slots with per-slot valid flags.
module desc_bank_loader #(
    parameter int DESC_BITS = 256,
    parameter int IN_W      = 8,
    parameter int NUM_DESC  = 4,
    localparam int BEATS    = DESC_BITS / IN_W,
    localparam int SLOT_W   = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1,
    localparam int BEAT_W   = $clog2(BEATS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SLOT_W-1:0]    slot,
    input  logic                 abort,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [IN_W-1:0]      in_data,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [BEAT_W-1:0]    beat_cnt,
    output logic [NUM_DESC-1:0]  desc_valid,
    input  logic [SLOT_W-1:0]    rd_slot,
    output logic [DESC_BITS-1:0] rd_data
);

    generate
        if ((DESC_BITS % IN_W) != 0) begin : g_bad_width
            $error("desc_bank_loader: DESC_BITS must be a multiple of IN_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic [SLOT_W-1:0]     slot_r;
    logic [DESC_BITS-1:0]  sreg_r;
    logic [BEAT_W-1:0]     beat_cnt_r;
    logic [NUM_DESC-1:0]   desc_valid_r;
    logic [NUM_DESC-1:0]   valid_next_s;
    logic [NUM_DESC-1:0]   start_mask_s;
    logic [NUM_DESC-1:0]   commit_mask_s;
    logic                  done_r;
    logic                  err_r;
    logic [DESC_BITS-1:0]  rd_data_r;
    logic [DESC_BITS-1:0]  bank_r [NUM_DESC];
    logic                  slot_ok_s;
    logic                  rd_ok_s;
    logic                  start_ok_s;
    logic                  abort_s;
    logic                  accept_s;
    logic                  last_beat_s;
    logic                  in_ready_s;
    logic                  busy_s;

    assign slot_ok_s   = (32'(slot) < NUM_DESC);
    assign rd_ok_s     = (32'(rd_slot) < NUM_DESC);
    assign start_ok_s  = (state_r == IDLE) && start && slot_ok_s;
    assign abort_s     = (state_r == LOAD) && abort;
    // abort wins over a beat offered in the same cycle
    assign accept_s    = (state_r == LOAD) && in_valid && !abort;
    assign last_beat_s = (beat_cnt_r == BEAT_W'(BEATS - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) next_state_s = LOAD;
                else            next_state_s = IDLE;
            end
            LOAD: begin
                if (abort)                        next_state_s = IDLE;
                else if (accept_s && last_beat_s) next_state_s = COMMIT;
                else                              next_state_s = LOAD;
            end
            COMMIT:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State-derived outputs
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
        case (state_r)
            IDLE:    begin in_ready_s = 1'b0; busy_s = 1'b0; end
            LOAD:    begin in_ready_s = 1'b1; busy_s = 1'b1; end
            COMMIT:  begin in_ready_s = 1'b0; busy_s = 1'b1; end
            default: begin in_ready_s = 1'b0; busy_s = 1'b0; end
        endcase
    end

    // Valid flags: clear first, then the new load's slot drops, then the commit sets
    always_comb begin
        start_mask_s  = {NUM_DESC{1'b0}};
        commit_mask_s = {NUM_DESC{1'b0}};
        for (int i = 0; i < NUM_DESC; i++) begin
            start_mask_s[i]  = start_ok_s && (slot == SLOT_W'(i));
            commit_mask_s[i] = (state_r == COMMIT) && (slot_r == SLOT_W'(i));
        end
        valid_next_s = ((clear ? {NUM_DESC{1'b0}} : desc_valid_r) & ~start_mask_s)
                       | commit_mask_s;
    end

    // Datapath and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_r       <= {SLOT_W{1'b0}};
            sreg_r       <= {DESC_BITS{1'b0}};
            beat_cnt_r   <= {BEAT_W{1'b0}};
            desc_valid_r <= {NUM_DESC{1'b0}};
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            rd_data_r    <= {DESC_BITS{1'b0}};
        end else begin
            desc_valid_r <= valid_next_s;
            done_r       <= (state_r == COMMIT);
            err_r        <= (state_r == IDLE) && start && !slot_ok_s;
            rd_data_r    <= rd_ok_s ? bank_r[rd_slot] : {DESC_BITS{1'b0}};
            if (start_ok_s) begin
                slot_r     <= slot;
                sreg_r     <= {DESC_BITS{1'b0}};
                beat_cnt_r <= {BEAT_W{1'b0}};
            end else if (abort_s) begin
                beat_cnt_r <= {BEAT_W{1'b0}};
            end else if (accept_s) begin
                sreg_r     <= (sreg_r << IN_W) | DESC_BITS'(in_data);
                beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            end else if (state_r == COMMIT) begin
                beat_cnt_r <= {BEAT_W{1'b0}};
            end
        end
    end

    // Bank storage, written only on the COMMIT exit edge
    always_ff @(posedge clk) begin
        if (state_r == COMMIT) begin
            bank_r[slot_r] <= sreg_r;
        end
    end

    assign in_ready   = in_ready_s;
    assign busy       = busy_s;
    assign done       = done_r;
    assign err        = err_r;
    assign beat_cnt   = beat_cnt_r;
    assign desc_valid = desc_valid_r;
    assign rd_data    = rd_data_r;

endmodule

// File: tb/tb_desc_bank_loader.sv
// Bench for desc_bank_loader: table-driven loads with a read-port scoreboard,
// plus hand sequences for abort, clear, err and mid-load reset.
module tb_desc_bank_loader;

    logic        clk;
    logic        rst;
    logic        start, abort, clear, in_valid;
    logic [1:0]  slot, rd_slot;
    logic [3:0]  in_data;
    logic        in_ready, busy, done, err;
    logic [2:0]  beat_cnt;
    logic [3:0]  desc_valid;
    logic [15:0] rd_data;

    logic        d3_rst, d3_start, d3_abort, d3_clear, d3_in_valid;
    logic [1:0]  d3_slot, d3_rd_slot;
    logic [3:0]  d3_in_data;
    logic        d3_in_ready, d3_busy, d3_done, d3_err;
    logic [2:0]  d3_beat_cnt;
    logic [2:0]  d3_desc_valid;
    logic [15:0] d3_rd_data;

    desc_bank_loader #(.DESC_BITS(16), .IN_W(4), .NUM_DESC(4)) dut (
        .clk(clk), .rst(rst), .start(start), .slot(slot), .abort(abort),
        .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .done(done), .err(err),
        .beat_cnt(beat_cnt), .desc_valid(desc_valid), .rd_slot(rd_slot),
        .rd_data(rd_data)
    );

    desc_bank_loader #(.DESC_BITS(16), .IN_W(4), .NUM_DESC(3)) dut3 (
        .clk(clk), .rst(d3_rst), .start(d3_start), .slot(d3_slot), .abort(d3_abort),
        .clear(d3_clear), .in_valid(d3_in_valid), .in_data(d3_in_data),
        .in_ready(d3_in_ready), .busy(d3_busy), .done(d3_done), .err(d3_err),
        .beat_cnt(d3_beat_cnt), .desc_valid(d3_desc_valid), .rd_slot(d3_rd_slot),
        .rd_data(d3_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;
    int unsigned cyc_cnt = 0;

    typedef struct {
        int unsigned due;
        logic [15:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [1:0]  slot;
        logic [15:0] data;
        bit          bubbles;
        bit          clr;
        bit          nxt;
        logic [1:0]  nslot;
        logic [3:0]  exp_valid;
    } vec_t;
    vec_t vecs[6];

    logic [15:0] mbank [4];
    bit          mknown[4];
    bit          in_load;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic rd_req(input logic [1:0] s, input logic [15:0] e);
        rd_slot = s;
        sbq.push_back('{due: cyc_cnt + 1, exp: e});
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Scoreboard: registered read data appears one cycle after the request
    always @(negedge clk) begin
        sb_t e;
        if (sbq.size() > 0 && sbq[0].due <= cyc_cnt) begin
            e = sbq.pop_front();
            chk("rd_data", {240'd0, rd_data}, {240'd0, e.exp});
        end
    end

    task automatic start_load(input logic [1:0] s);
        start = 1'b1;
        slot  = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beats(input logic [15:0] d, input bit bubbles);
        for (int i = 0; i < 4; i++) begin
            chk("beat_cnt", beat_cnt, i);
            chk("in_ready", in_ready, 1);
            in_valid = 1'b1;
            in_data  = d[15-4*i -: 4];
            @(negedge clk);
            if (bubbles && i < 3) begin
                in_valid = 1'b0;
                chk("stall_cnt", beat_cnt, i + 1);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic commit(input logic [1:0] s, input logic [15:0] d, input bit clr,
                          input bit nxt, input logic [1:0] nslot, input logic [3:0] expv);
        chk("commit_busy", busy, 1);
        chk("commit_ready", in_ready, 0);
        chk("commit_cnt", beat_cnt, 4);
        chk("commit_done", done, 0);
        clear = clr;
        if (mknown[s]) rd_req(s, mbank[s]);
        @(negedge clk);
        clear = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_cnt", beat_cnt, 0);
        chk("desc_valid", desc_valid, expv);
        mbank[s]  = d;
        mknown[s] = 1'b1;
        rd_req(s, d);
        if (nxt) begin
            start = 1'b1;
            slot  = nslot;
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_once", done, 0);
        chk("b2b_busy", busy, nxt);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (!in_load) start_load(vecs[i].slot);
            beats(vecs[i].data, vecs[i].bubbles);
            commit(vecs[i].slot, vecs[i].data, vecs[i].clr, vecs[i].nxt,
                   vecs[i].nslot, vecs[i].exp_valid);
            in_load = vecs[i].nxt;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2'd2, 16'hABCD, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100};
        vecs[1] = '{2'd1, 16'h1234, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0110};
        vecs[2] = '{2'd0, 16'h5A5A, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0111};
        vecs[3] = '{2'd2, 16'hABCD, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0100};
        vecs[4] = '{2'd3, 16'hFEDC, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1100};
        vecs[5] = '{2'd3, 16'h3C3C, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1000};
        for (int i = 0; i < 4; i++) mknown[i] = 1'b0;
        in_load = 1'b0;

        rst = 1'b0; start = 1'b0; abort = 1'b0; clear = 1'b0; in_valid = 1'b0;
        slot = 2'd0; rd_slot = 2'd0; in_data = 4'd0;
        d3_rst = 1'b0; d3_start = 1'b0; d3_abort = 1'b0; d3_clear = 1'b0;
        d3_in_valid = 1'b0; d3_slot = 2'd0; d3_rd_slot = 2'd0; d3_in_data = 4'd0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk("rst_desc_valid", desc_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b1;
        d3_rst = 1'b1;
        @(negedge clk);
        chk("rel_busy", busy, 0);
        chk("rel_in_ready", in_ready, 0);

        run_vecs(0, 2);

        // Abort with a beat present; a start during LOAD is ignored
        start_load(2'd0);
        in_valid = 1'b1; in_data = 4'h1;
        @(negedge clk);
        in_data = 4'h2; start = 1'b1; slot = 2'd3;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_load_err", err, 0);
        chk("abort_pre_cnt", beat_cnt, 2);
        in_data = 4'h3; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_cnt", beat_cnt, 0);
        chk("abort_done", done, 0);
        chk("abort_valid", desc_valid, 4'b0110);
        rd_req(2'd0, 16'h5A5A);
        @(negedge clk);
        chk("abort_no_done", done, 0);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_valid", desc_valid, 0);

        run_vecs(3, 5);

        // clear together with an IDLE start
        clear = 1'b1; start = 1'b1; slot = 2'd1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        chk("clr_start_valid", desc_valid, 0);
        chk("clr_start_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("clr_start_abort", busy, 0);

        // NUM_DESC=3 instance: out-of-range start
        d3_start = 1'b1; d3_slot = 2'd3;
        @(negedge clk);
        d3_start = 1'b0;
        chk("d3_err", d3_err, 1);
        chk("d3_err_busy", d3_busy, 0);
        chk("d3_err_valid", d3_desc_valid, 0);
        @(negedge clk);
        chk("d3_err_pulse", d3_err, 0);

        d3_start = 1'b1; d3_slot = 2'd1;
        @(negedge clk);
        d3_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d3_in_valid = 1'b1;
            d3_in_data  = (i == 0) ? 4'hC : (i == 1) ? 4'h0 : (i == 2) ? 4'hD : 4'hE;
            @(negedge clk);
        end
        d3_in_valid = 1'b0;
        @(negedge clk);
        chk("d3_done", d3_done, 1);
        chk("d3_valid", d3_desc_valid, 3'b010);
        d3_rd_slot = 2'd1;
        @(negedge clk);
        chk("d3_rd", d3_rd_data, 16'hC0DE);
        d3_rd_slot = 2'd3;
        @(negedge clk);
        chk("d3_rd_oob", d3_rd_data, 0);
        d3_rd_slot = 2'd1;

        // Reset mid-load
        d3_start = 1'b1; d3_slot = 2'd2;
        @(negedge clk);
        d3_start = 1'b0;
        d3_in_valid = 1'b1; d3_in_data = 4'h7;
        @(negedge clk);
        d3_in_data = 4'h8;
        @(negedge clk);
        chk("d3_mid_cnt", d3_beat_cnt, 2);
        chk("d3_mid_rd", d3_rd_data, 16'hC0DE);
        #2 d3_rst = 1'b0;
        #1;
        chk("d3_rst_busy", d3_busy, 0);
        chk("d3_rst_ready", d3_in_ready, 0);
        chk("d3_rst_cnt", d3_beat_cnt, 0);
        chk("d3_rst_valid", d3_desc_valid, 0);
        chk("d3_rst_rd", d3_rd_data, 0);
        @(negedge clk);
        d3_in_valid = 1'b0;
        d3_rst = 1'b1;
        @(negedge clk);
        chk("d3_post_rst_done", d3_done, 0);

        @(negedge clk);
        chk("sb_drain", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
